// File: rtl/param_dmem_pkg.sv
// -----------------------------------------------------------------------------
// param_dmem_pkg
// Shared types and helpers for the param_dmem data memory.
//   dmem_state_e : controller state (INIT sweep, RUN service, DRAIN before re-init)
//   be_merge     : byte-lane merge, picks the new byte when its enable is set
//   byte_parity  : even-parity bit of one byte (XOR of its bits)
// Optional feature macro used by the including files: PARAM_DMEM_PARITY_EN
// -----------------------------------------------------------------------------
package param_dmem_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dmem_state_e;

    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

    // Even parity: stored bit makes the total number of ones even.
    function automatic logic byte_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/param_dmem_array.sv
// -----------------------------------------------------------------------------
// param_dmem_array
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. The read register only loads when re is high, so it doubles as
// the response data holding register of the parent.
// Ports:
//   clk, resetn          clock, async active-low reset (read register only)
//   we, be, addr, wdata  byte-enabled write
//   re                   load mem[addr] into rdata on this edge
//   rdata                registered read data (holds when re is low)
//   perr                 (PARAM_DMEM_PARITY_EN only) registered parity error
// Macro: PARAM_DMEM_PARITY_EN adds one even-parity bit per stored byte.
// The storage array itself is not reset.
// -----------------------------------------------------------------------------
module param_dmem_array
    import param_dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
`ifdef PARAM_DMEM_PARITY_EN
    output logic                  perr,
`endif
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                mem[addr][8*i +: 8] <= be_merge(mem[addr][8*i +: 8], wdata[8*i +: 8], be[i]);
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef PARAM_DMEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          perr_d, perr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par_mem[addr][i] <= byte_parity(wdata[8*i +: 8]);
                end
            end
        end
    end

    // Recompute parity of the stored word and compare lane by lane.
    always_comb begin
        perr_d = perr_q;
        if (re) begin
            perr_d = 1'b0;
            for (int i = 0; i < NB; i++) begin
                if (par_mem[addr][i] != byte_parity(mem[addr][8*i +: 8])) begin
                    perr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`endif

endmodule

// File: rtl/param_dmem.sv
// -----------------------------------------------------------------------------
// param_dmem
// Parametrised single-port data RAM with valid/ready request and response
// channels, per-byte write enables, 1-cycle registered read, and a hardware
// init sweep (after reset and on clr_req) writing INIT_VAL to every word.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   clr_req                     pulse: re-initialise memory (honoured in RUN)
//   init_busy                   high in INIT or DRAIN
//   req_valid/req_ready         request handshake
//   req_we, req_addr,
//   req_wdata, req_be           request payload (be bit i -> byte [8i+7:8i])
//   rsp_valid/rsp_ready         response handshake (reads only)
//   rsp_rdata                   read data, held while stalled
//   rsp_perr                    (PARAM_DMEM_PARITY_EN only) parity error flag
//   dbg_state                   current controller state
// Macro: PARAM_DMEM_PARITY_EN enables per-byte parity storage and rsp_perr.
//
// Handshake rule: a transfer happens on a rising edge where valid && ready
// are both high; valid must not depend on ready. req_ready in RUN is
// !rsp_valid || rsp_ready, a combinational path from rsp_ready, so a read
// can be accepted in the same cycle the previous response is taken.
// -----------------------------------------------------------------------------
module param_dmem
    import param_dmem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_req,
    output logic                  init_busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
`ifdef PARAM_DMEM_PARITY_EN
    output logic                  rsp_perr,
`endif
    output dmem_state_e           dbg_state
);

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    dmem_state_e        state_d, state_q;
    logic [ADDR_W-1:0]  init_cnt_d, init_cnt_q;
    logic               rsp_valid_d, rsp_valid_q;

    logic               req_acc;
    logic               arr_we;
    logic               arr_re;
    logic [NB-1:0]      arr_be;
    logic [ADDR_W-1:0]  arr_addr;
    logic [DATA_W-1:0]  arr_wdata;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 1'b0;
        init_busy   = 1'b1;
        arr_we      = 1'b0;
        arr_re      = 1'b0;
        arr_be      = '0;
        arr_addr    = req_addr;
        arr_wdata   = req_wdata;

        case (state_q)
            INIT: begin
                // The sweep owns the RAM port; clr_req is ignored here.
                arr_we     = 1'b1;
                arr_be     = '1;
                arr_addr   = init_cnt_q;
                arr_wdata  = INIT_VAL;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end
            end
            RUN: begin
                init_busy = 1'b0;
                req_ready = !rsp_valid_q || rsp_ready;
                if (clr_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the outstanding response to leave before wiping.
                if (!rsp_valid_q) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase

        req_acc = req_valid && req_ready;
        if (req_acc) begin
            arr_we = req_we;
            arr_be = req_be;
            arr_re = !req_we;
        end

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (arr_re) begin
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign dbg_state = state_q;

    param_dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .resetn (resetn),
        .we     (arr_we),
        .be     (arr_be),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .re     (arr_re),
`ifdef PARAM_DMEM_PARITY_EN
        .perr   (rsp_perr),
`endif
        .rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_param_dmem.sv
// -----------------------------------------------------------------------------
// tb_param_dmem
// Bench for param_dmem with DATA_W=32, ADDR_W=4, INIT_VAL=32'hA5A5_A5A5.
// Optional feature macro: PARAM_DMEM_PARITY_EN (adds the rsp_perr section).
// -----------------------------------------------------------------------------
module tb_param_dmem;
    import param_dmem_pkg::*;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 4;
    localparam int          NB     = 4;
    localparam logic [31:0] IV     = 32'hA5A5_A5A5;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn;
    always #5 clk = ~clk;

    logic        clr_req;
    logic        init_busy;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
`ifdef PARAM_DMEM_PARITY_EN
    logic        rsp_perr;
`endif
    dmem_state_e dbg_state;

    param_dmem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (IV)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clr_req   (clr_req),
        .init_busy (init_busy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef PARAM_DMEM_PARITY_EN
        .rsp_perr  (rsp_perr),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_pass   = 0;
    int          n_checks = 0;
    int          rsp_cnt  = 0;
    logic        ready_in_init = 1'b0;
    logic        busy_low_in_init = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // ---------------- driver ----------------
    // Entered at a falling edge; drives one cycle, scores the response seen
    // on the following rising edge and returns at the next falling edge.
    task automatic step(input logic v, input logic we, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic rr, input logic clr, input logic [31:0] exp,
                        output logic acc);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = rr;
        clr_req   = clr;
        #1;
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) check1("rsp_spurious", 1'b1, 1'b0);
            else check32("rsp_data", rsp_rdata, exp_q.pop_front());
        end
        acc = v && req_ready;
        if (acc && !we) exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b0;
        clr_req   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
        logic acc;
        step(1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b1, 1'b0, exp, acc);
        check1("rd_acc", acc, 1'b1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic acc;
        step(1'b1, 1'b1, addr, data, be, 1'b1, 1'b0, 32'h0, acc);
        check1("wr_acc", acc, 1'b1);
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, acc);
    endtask

    // Counts INIT cycles until RUN (DRAIN cycles are passed through). A read
    // request is held the whole time; it must never be accepted.
    task automatic wait_init(input logic pulse_clr, output int n);
        int guard;
        n = 0;
        guard = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        rsp_ready = 1'b1;
        while (dbg_state != RUN && guard < 100) begin
            if (dbg_state == INIT) n++;
            clr_req = pulse_clr && (n == 3);
            #1;
            if (req_ready) ready_in_init = 1'b1;
            if (!init_busy) busy_low_in_init = 1'b1;
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        clr_req   = 1'b0;
        if (guard >= 100) check1("init_timeout", 1'b1, 1'b0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] burst_exp[16];

    initial begin
        int   n;
        int   base;
        logic acc;

        tbl[0]  = '{1'b1, 4'd3, 32'h1122_3344, 4'b0101, 32'h0};
        tbl[1]  = '{1'b0, 4'd3, 32'h0,         4'b0000, 32'hA522_A544};
        tbl[2]  = '{1'b1, 4'd4, 32'hCAFE_F00D, 4'b1111, 32'h0};
        tbl[3]  = '{1'b1, 4'd4, 32'h0000_0000, 4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 4'd4, 32'h0,         4'b0000, 32'hCAFE_F00D};
        tbl[5]  = '{1'b1, 4'd5, 32'h1234_5678, 4'b1000, 32'h0};
        tbl[6]  = '{1'b0, 4'd5, 32'h0,         4'b0000, 32'h12A5_A5A5};
        tbl[7]  = '{1'b0, 4'd3, 32'h0,         4'b0000, 32'hA522_A544};
        tbl[8]  = '{1'b1, 4'd3, 32'hFFFF_FFFF, 4'b1111, 32'h0};
        tbl[9]  = '{1'b0, 4'd3, 32'h0,         4'b0000, 32'hFFFF_FFFF};
        tbl[10] = '{1'b1, 4'd6, 32'h89AB_CDEF, 4'b0110, 32'h0};
        tbl[11] = '{1'b0, 4'd6, 32'h0,         4'b0000, 32'hA5AB_CDA5};

        for (int i = 0; i < 16; i++) burst_exp[i] = IV;
        burst_exp[3] = 32'hFFFF_FFFF;
        burst_exp[4] = 32'hCAFE_F00D;
        burst_exp[5] = 32'h12A5_A5A5;
        burst_exp[6] = 32'hA5AB_CDA5;

        resetn    = 1'b0;
        clr_req   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h7;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;

        // ---- reset values ----
        #2;
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("rst_init_busy", init_busy, 1'b1);
        check1("rst_req_ready", req_ready, 1'b0);
        check32("rst_state", 32'(dbg_state), 32'(INIT));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // ---- first sweep: exactly 16 busy cycles ----
        wait_init(1'b0, n);
        check32("sweep_len", 32'(n), 32'd16);
        check1("ready_in_init", ready_in_init, 1'b0);
        check1("busy_in_init", busy_low_in_init, 1'b0);
        check1("busy_after_sweep", init_busy, 1'b0);

        // ---- first read: 1-cycle latency ----
        rd(4'd7, IV);
        check1("rd7_valid", rsp_valid, 1'b1);
        check32("rd7_data", rsp_rdata, IV);

        // ---- table-driven writes / reads ----
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1, 1'b0, tbl[i].exp, acc);
            check1($sformatf("tbl%0d_acc", i), acc, 1'b1);
        end
        idle(1);
        check32("tbl_drained", 32'(exp_q.size()), 32'd0);

        // ---- back-to-back reads 0..15 ----
        base = rsp_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) check1($sformatf("burst_valid%0d", i), rsp_valid, 1'b1);
            step(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1, 1'b0, burst_exp[i], acc);
            check1($sformatf("burst_acc%0d", i), acc, 1'b1);
        end
        check1("burst_last_valid", rsp_valid, 1'b1);
        idle(1);
        check32("burst_cnt", 32'(rsp_cnt - base), 32'd16);

        // ---- backpressure: stalled response blocks requests ----
        rd(4'd5, 32'h12A5_A5A5);
        for (int k = 0; k < 4; k++) begin
            check1("bp_valid", rsp_valid, 1'b1);
            check32("bp_stable", rsp_rdata, 32'h12A5_A5A5);
            step(1'b1, 1'b0, 4'd6, 32'h0, 4'h0, 1'b0, 1'b0, 32'hA5AB_CDA5, acc);
            check1("bp_ready_low", acc, 1'b0);
        end
        step(1'b1, 1'b0, 4'd6, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA5AB_CDA5, acc);
        check1("bp_same_cycle_acc", acc, 1'b1);
        idle(1);

        // ---- clear while a response is stalled ----
        wr(4'd9, 32'hDEAD_BEEF, 4'b1111);
        rd(4'd9, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, acc);
        check32("clr_drain", 32'(dbg_state), 32'(DRAIN));
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, IV, acc);
            check1("drain_no_acc", acc, 1'b0);
            check1("drain_busy", init_busy, 1'b1);
            check32("drain_hold", 32'(dbg_state), 32'(DRAIN));
            check1("drain_rsp_held", rsp_valid, 1'b1);
        end
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, acc);
        wait_init(1'b1, n);
        check32("clr_sweep_len", 32'(n), 32'd16);
        rd(4'd9, IV);
        rd(4'd3, IV);
        idle(1);

        // ---- async reset in RUN with a stalled response ----
        wr(4'd2, 32'hDEAD_BEEF, 4'b1111);
        step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, acc);
        check1("pre_rst_valid", rsp_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check1("arst_rsp_valid", rsp_valid, 1'b0);
        check32("arst_rsp_rdata", rsp_rdata, 32'h0);
        check1("arst_busy", init_busy, 1'b1);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        wait_init(1'b0, n);
        check32("arst_sweep_len", 32'(n), 32'd16);

        // ---- reset at cycle 8 of a sweep ----
        wr(4'd2, 32'hDEAD_BEEF, 4'b1111);
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, acc);
        idle(1);
        check32("mid_in_init", 32'(dbg_state), 32'(INIT));
        repeat (8) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check1("mid_rst_valid", rsp_valid, 1'b0);
        check32("mid_rst_state", 32'(dbg_state), 32'(INIT));
        @(negedge clk);
        resetn = 1'b1;
        wait_init(1'b0, n);
        check32("mid_sweep_len", 32'(n), 32'd16);
        rd(4'd0, IV);
        rd(4'd2, IV);
        rd(4'd15, IV);
        idle(1);

`ifdef PARAM_DMEM_PARITY_EN
        // ---- parity: corrupt one stored parity bit of addr 2 ----
        rd(4'd3, IV);
        check1("perr_clean", rsp_perr, 1'b0);
        dut.u_array.par_mem[2][0] = ~dut.u_array.par_mem[2][0];
        rd(4'd2, IV);
        check1("perr_flip", rsp_perr, 1'b1);
        idle(1);
`endif

        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check1("final_no_ready_in_init", ready_in_init, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/param_dmem.md
Name: param_dmem

Overview:
- Parametrised single-port data RAM with a valid/ready request channel and a valid/ready response channel.
- Per-byte write enables and a registered 1-cycle read.
- Response register holds read data under backpressure.
- Hardware init sweep after reset and on software clear request.
- Drop-in successor data memory for the simple ISA core and its SystemC-matched RTL model.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 8, word address width; DEPTH = 2**ADDR_W words
INIT_VAL, 0, DATA_W-bit value written to every word by the init sweep

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
clr_req  input  1  pulse: re-initialise the whole memory to INIT_VAL
init_busy  output  1  high while FSM is in INIT or DRAIN
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_be  input  DATA_W/8  byte enables, bit i covers byte [8i+7:8i]
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  read data

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on resetn.
  - Reset values: state=INIT, init counter=0, rsp_valid=0, rsp_rdata=0, init_busy=1.
  - Memory array is not reset; its contents are defined only by the init sweep.
- FSM states: INIT, RUN, DRAIN.
  - INIT:
    - Writes INIT_VAL (all bytes) to address init_cnt each cycle; init_cnt increments.
    - After writing DEPTH-1, goes to RUN.
    - Sweep takes exactly DEPTH cycles.
    - req_ready=0 throughout.
  - RUN:
    - req_ready = !rsp_valid || rsp_ready. This is a combinational path from rsp_ready.
    - When clr_req=1 in RUN: go to DRAIN next cycle. A request accepted in the same cycle still completes.
  - DRAIN:
    - req_ready=0.
    - Stays until rsp_valid=0, then goes to INIT with init_cnt=0.
    - Further clr_req pulses are ignored.
  - clr_req in INIT is ignored; the sweep is not restarted.
- Write on accept:
  - Only bytes with req_be[i]=1 are updated, at the accepting edge.
  - No response is generated.
  - be=0 is a legal no-op.
- Read on accept:
  - mem[req_addr] is captured into rsp_rdata at the accepting edge, and rsp_valid=1 the next cycle (latency 1).
- Response register:
  - Holds rsp_rdata stable while rsp_valid && !rsp_ready.
  - Clears rsp_valid on handshake unless a new read is accepted in the same cycle. Back-to-back reads sustain 1 per cycle.
- Ordering:
  - Single port, one request per cycle.
  - A write following a read to the same address does not alter the earlier response (read data is captured at accept).
  - A read following a write returns the new data.
- Address wrap: not applicable; every ADDR_W value is a valid word.
- Reset mid-sweep or mid-drain restarts from INIT at address 0.

Optional Feature:
- Macro: PARAM_DMEM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte, computed on every write (including the init sweep).
  - Added port: rsp_perr, output, 1 bit.
  - rsp_perr is registered alongside rsp_rdata and is 1 if any byte's stored parity mismatches its data.
  - Reset value of rsp_perr is 0.
- When undefined: no parity storage and no rsp_perr port.

Decomposition:
- Package param_dmem_pkg holds:
  - State enum dmem_state_e {INIT, RUN, DRAIN}.
  - Function be_merge(old, new, be).
  - Function byte_parity(data).
- One sub-module, param_dmem_array:
  - Plain synchronous byte-enabled RAM with registered read.
  - Parity bits are included under the macro.
  - Keeps the FSM and handshake logic separate from inferable storage.

Test Plan (DATA_W=32, ADDR_W=4, INIT_VAL=32'hA5A5_A5A5):
- Release reset -> init_busy=1 and req_ready=0 for exactly 16 cycles; then a read of addr 7 returns 32'hA5A5A5A5 one cycle after accept.
- Write addr 3 = 32'h1122_3344 with be=4'b0101, then read 3 -> 32'hA522_A544.
- Back-to-back reads of addrs 0..15 with rsp_ready=1 -> 16 responses on consecutive cycles, in order, no bubbles.
- Read addr 5, hold rsp_ready=0 for 4 cycles while req_valid=1 -> req_ready=0, rsp_rdata stable. Then rsp_ready=1 -> handshake, and the next request is accepted in the same cycle.
- Write 32'hDEAD_BEEF to addr 9, pulse clr_req while a read response is stalled -> DRAIN holds until the response is taken, then a 16-cycle INIT; a subsequent read of addr 9 returns 32'hA5A5A5A5.
- Assert resetn=0 at cycle 8 of the sweep -> rsp_valid=0 immediately; after release a full 16-cycle sweep runs from addr 0. With PARAM_DMEM_PARITY_EN, forcing a stored parity bit flip on addr 2 -> reading addr 2 gives rsp_perr=1.
